// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction fetches and load/stores onto one byte-wide RAM port.
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests (default: MEM has fixed priority).
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_cancel,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic [2:0]         nbytes_reg, nbytes_next;
    logic [ADDR_W-1:0]  base_reg, base_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [31:0]        rd_buf_reg, rd_buf_next;
    logic [31:0]        if_data_reg, if_data_next;
    logic [31:0]        mem_rdata_reg, mem_rdata_next;
    logic               if_ready_reg, if_ready_next;
    logic               mem_ready_reg, mem_ready_next;
    logic [ADDR_W-1:0]  ram_addr_reg, ram_addr_next;
    logic               ram_wr_reg, ram_wr_next;
    logic [7:0]         ram_dout_reg, ram_dout_next;

    logic               if_pend;
    logic               grant_if;
    logic               grant_mem;
    logic [2:0]         mem_nbytes;
    logic [2:0]         cnt_inc;
    logic               rd_active;
    logic [31:0]        rd_buf_cap;
    logic [7:0]         wbyte [4];

    // Address bits above ADDR_W are intentionally ignored.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    assign if_pend = if_req && !if_cancel;

`ifdef MEM_ARB_RR_EN
    logic last_grant_mem_reg;
    assign grant_mem = mem_req && (!if_pend || !last_grant_mem_reg);
`else
    assign grant_mem = mem_req;
`endif
    assign grant_if = if_pend && !grant_mem;

    assign mem_nbytes = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
    assign cnt_inc    = cnt_reg + 3'd1;
    assign rd_active  = (state_reg == IF_RD) || (state_reg == MEM_RD);

    // Read data of beat k arrives one cycle after its address, i.e. while cnt == k+1.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_buf_cap[8*gi +: 8] = (rd_active && cnt_reg == 3'(gi + 1)) ?
                                           ram_din : rd_buf_reg[8*gi +: 8];
            assign wbyte[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        nbytes_next    = nbytes_reg;
        base_next      = base_reg;
        wdata_next     = wdata_reg;
        rd_buf_next    = rd_buf_cap;
        if_data_next   = if_data_reg;
        mem_rdata_next = mem_rdata_reg;
        if_ready_next  = 1'b0;
        mem_ready_next = 1'b0;
        ram_addr_next  = ram_addr_reg;
        ram_wr_next    = 1'b0;
        ram_dout_next  = ram_dout_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (grant_mem) begin
                    base_next     = mem_addr[ADDR_W-1:0];
                    nbytes_next   = mem_nbytes;
                    wdata_next    = mem_wdata;
                    rd_buf_next   = '0;
                    ram_addr_next = mem_addr[ADDR_W-1:0];
                    if (mem_write) begin
                        state_next    = MEM_WR;
                        ram_wr_next   = 1'b1;
                        ram_dout_next = mem_wdata[7:0];
                    end else begin
                        state_next = MEM_RD;
                    end
                end else if (grant_if) begin
                    base_next     = if_addr[ADDR_W-1:0];
                    nbytes_next   = 3'd4;
                    rd_buf_next   = '0;
                    ram_addr_next = if_addr[ADDR_W-1:0];
                    state_next    = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if (state_reg == IF_RD && if_cancel) begin
                    state_next = IDLE;
                end else if (cnt_reg == nbytes_reg) begin
                    // Drain cycle: last byte lands now, publish the assembled word.
                    state_next = DONE;
                    if (state_reg == IF_RD) begin
                        if_ready_next = 1'b1;
                        if_data_next  = rd_buf_cap;
                    end else begin
                        mem_ready_next = 1'b1;
                        mem_rdata_next = rd_buf_cap;
                    end
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc < nbytes_reg) begin
                        ram_addr_next = base_reg + ADDR_W'(cnt_inc);
                    end
                end
            end
            MEM_WR: begin
                cnt_next = cnt_inc;
                if (cnt_inc < nbytes_reg) begin
                    ram_wr_next   = 1'b1;
                    ram_addr_next = base_reg + ADDR_W'(cnt_inc);
                    ram_dout_next = wbyte[cnt_inc[1:0]];
                end else begin
                    state_next     = DONE;
                    mem_ready_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            nbytes_reg    <= '0;
            base_reg      <= '0;
            wdata_reg     <= '0;
            rd_buf_reg    <= '0;
            if_data_reg   <= '0;
            mem_rdata_reg <= '0;
            if_ready_reg  <= 1'b0;
            mem_ready_reg <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wr_reg    <= 1'b0;
            ram_dout_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            nbytes_reg    <= nbytes_next;
            base_reg      <= base_next;
            wdata_reg     <= wdata_next;
            rd_buf_reg    <= rd_buf_next;
            if_data_reg   <= if_data_next;
            mem_rdata_reg <= mem_rdata_next;
            if_ready_reg  <= if_ready_next;
            mem_ready_reg <= mem_ready_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wr_reg    <= ram_wr_next;
            ram_dout_reg  <= ram_dout_next;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Reset value 0 means "IF granted last", so MEM wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_mem_reg <= 1'b0;
        end else if (state_reg == IDLE && (grant_mem || grant_if)) begin
            last_grant_mem_reg <= grant_mem;
        end
    end
`endif

    assign if_ready  = if_ready_reg;
    assign if_data   = if_data_reg;
    assign mem_ready = mem_ready_reg;
    assign mem_rdata = mem_rdata_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wr    = ram_wr_reg;
    assign ram_dout  = ram_dout_reg;
    assign busy      = (state_reg != IDLE);

endmodule
